// File: rtl/display_pkg.sv
// +----------------------------------------------------------------------------+
// | display_pkg : shared types, 640x480@60 timing constants, colour-bar table   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package display_pkg;

  typedef logic [9:0] coord_t;
  typedef logic [3:0] colour_t;

  typedef struct packed {
    colour_t r;
    colour_t g;
    colour_t b;
  } rgb_t;

  localparam coord_t H_RES   = 10'd640;
  localparam coord_t H_FP    = 10'd16;
  localparam coord_t H_SYNC  = 10'd96;
  localparam coord_t H_BP    = 10'd48;
  localparam coord_t V_RES   = 10'd480;
  localparam coord_t V_FP    = 10'd10;
  localparam coord_t V_SYNC  = 10'd2;
  localparam coord_t V_BP    = 10'd33;

  localparam coord_t H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam coord_t V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  localparam coord_t BAR_WIDTH = 10'd80;

  // Left-to-right bar order across the active area.
  localparam rgb_t BAR_COLOURS [8] = '{
    '{4'hF, 4'hF, 4'hF},
    '{4'hF, 4'hF, 4'h0},
    '{4'h0, 4'hF, 4'hF},
    '{4'h0, 4'hF, 4'h0},
    '{4'hF, 4'h0, 4'hF},
    '{4'hF, 4'h0, 4'h0},
    '{4'h0, 4'h0, 4'hF},
    '{4'h0, 4'h0, 4'h0}
  };

endpackage

`default_nettype wire

// File: rtl/display_testpat.sv
// +----------------------------------------------------------------------------+
// | display_testpat : 8 vertical colour bars, registered in step with de        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module display_testpat
  import display_pkg::*;
(
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       pix_ce_i,
  input  logic [9:0] sx_i,
  input  logic       de_i,
  output logic [3:0] r_o,
  output logic [3:0] g_o,
  output logic [3:0] b_o
);

  rgb_t   rgb_q;
  rgb_t   rgb_d;
  logic [2:0] bar_idx;

  // sx_i/de_i are next-state values, so the register lands in the same cycle as de.
  always_comb begin
    bar_idx = 3'(sx_i / BAR_WIDTH);
    rgb_d   = '0;
    if (de_i) begin
      rgb_d = BAR_COLOURS[bar_idx];
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      rgb_q <= '0;
    end else if (pix_ce_i) begin
      rgb_q <= rgb_d;
    end
  end

  assign r_o = rgb_q.r;
  assign g_o = rgb_q.g;
  assign b_o = rgb_q.b;

endmodule

`default_nettype wire

// File: rtl/display_timings_480p.sv
// +----------------------------------------------------------------------------+
// | display_timings_480p : 640x480@60 VGA timing generator (pix_ce-advanced)   |
// | Optional colour-bar outputs r/g/b when DISPLAY_TESTPAT_EN is defined.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module display_timings_480p
  import display_pkg::*;
#(
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       pix_ce,
  output logic [9:0] sx,
  output logic [9:0] sy,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       line,
  output logic       frame
`ifdef DISPLAY_TESTPAT_EN
  ,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b
`endif
);

  localparam coord_t H_MAX    = H_TOTAL - 10'd1;
  localparam coord_t V_MAX    = V_TOTAL - 10'd1;
  localparam coord_t HS_START = H_RES + H_FP;
  localparam coord_t HS_END   = H_RES + H_FP + H_SYNC - 10'd1;
  localparam coord_t VS_START = V_RES + V_FP;
  localparam coord_t VS_END   = V_RES + V_FP + V_SYNC - 10'd1;

  coord_t sx_q, sx_d;
  coord_t sy_q, sy_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   de_q, de_d;
  logic   line_q;
  logic   frame_q;

  // Decode from the advanced position so sync/de line up with sx/sy.
  always_comb begin
    sx_d = sx_q + 10'd1;
    sy_d = sy_q;
    if (sx_q == H_MAX) begin
      sx_d = '0;
      sy_d = (sy_q == V_MAX) ? '0 : sy_q + 10'd1;
    end
    hsync_d = ((sx_d >= HS_START) && (sx_d <= HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d = ((sy_d >= VS_START) && (sy_d <= VS_END)) ? SYNC_POL : ~SYNC_POL;
    de_d    = (sx_d < H_RES) && (sy_d < V_RES);
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      sx_q    <= H_MAX;
      sy_q    <= V_MAX;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      de_q    <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      // Strobes self-clear on the following edge regardless of pix_ce.
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      if (pix_ce) begin
        sx_q    <= sx_d;
        sy_q    <= sy_d;
        hsync_q <= hsync_d;
        vsync_q <= vsync_d;
        de_q    <= de_d;
        line_q  <= (sx_d == '0);
        frame_q <= (sx_d == '0) && (sy_d == '0);
      end
    end
  end

  assign sx    = sx_q;
  assign sy    = sy_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign de    = de_q;
  assign line  = line_q;
  assign frame = frame_q;

`ifdef DISPLAY_TESTPAT_EN
  display_testpat u_testpat (
    .clk_50m  (clk_50m),
    .rst      (rst),
    .pix_ce_i (pix_ce),
    .sx_i     (sx_d),
    .de_i     (de_d),
    .r_o      (r),
    .g_o      (g),
    .b_o      (b)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_display_timings_480p.sv
// +----------------------------------------------------------------------------+
// | tb_display_timings_480p : self-checking bench for display_timings_480p      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_display_timings_480p;

  logic       clk_50m;
  logic       rst;
  logic       pix_ce;
  logic [9:0] sx;
  logic [9:0] sy;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic       line;
  logic       frame;
`ifdef DISPLAY_TESTPAT_EN
  logic [3:0] r, g, b;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  display_timings_480p dut (
    .clk_50m (clk_50m),
    .rst     (rst),
    .pix_ce  (pix_ce),
    .sx      (sx),
    .sy      (sy),
    .hsync   (hsync),
    .vsync   (vsync),
    .de      (de),
    .line    (line),
    .frame   (frame)
`ifdef DISPLAY_TESTPAT_EN
    ,
    .r       (r),
    .g       (g),
    .b       (b)
`endif
  );

  initial clk_50m = 1'b0;
  always #10 clk_50m = ~clk_50m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Model: the raster is one linear pixel index over an 800x525 frame.
  int unsigned m_idx   = 0;
  bit          m_str   = 1'b0;
  bit          m_valid = 1'b0;

  always @(posedge clk_50m) begin
    if (rst) begin
      m_idx   <= 800 * 525 - 1;
      m_str   <= 1'b0;
      m_valid <= 1'b1;
    end else if (pix_ce) begin
      m_idx   <= (m_idx + 1) % (800 * 525);
      m_str   <= 1'b1;
    end else begin
      m_str   <= 1'b0;
    end
  end

  function automatic int mx(); return int'(m_idx % 800); endfunction
  function automatic int my(); return int'(m_idx / 800); endfunction

`ifdef DISPLAY_TESTPAT_EN
  logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
`endif

  always @(negedge clk_50m) begin
    if (m_valid) begin
      chk("sx", 32'(sx), mx());
      chk("sy", 32'(sy), my());
      chk("hsync", 32'(hsync), (mx() >= 656 && mx() <= 751) ? 0 : 1);
      chk("vsync", 32'(vsync), (my() >= 490 && my() <= 491) ? 0 : 1);
      chk("de", 32'(de), (mx() < 640 && my() < 480) ? 1 : 0);
      chk("line", 32'(line), (m_str && mx() == 0) ? 1 : 0);
      chk("frame", 32'(frame), (m_str && m_idx == 0) ? 1 : 0);
`ifdef DISPLAY_TESTPAT_EN
      chk("rgb", 32'({r, g, b}), (mx() < 640 && my() < 480) ? 32'(bars[mx() / 80]) : 32'd0);
`endif
    end
  end

  task automatic step(input bit ce);
    pix_ce = ce;
    @(negedge clk_50m);
  endtask

  int hs_cnt, de_cnt, hs_first, hs_last;
  int strobes, lines, vs_lines, vs_first, vs_last, de_bad, max_x, max_y, p_sx, p_sy;
  bit seen_first, done;

  initial begin
    rst    = 1'b1;
    pix_ce = 1'b0;
    @(negedge clk_50m);
    step(1); step(0); step(1);
    chk("rst_sx", 32'(sx), 799);
    chk("rst_sy", 32'(sy), 524);
    chk("rst_hsync", 32'(hsync), 1);
    chk("rst_vsync", 32'(vsync), 1);
    chk("rst_de", 32'(de), 0);
    chk("rst_line_frame", 32'({line, frame}), 0);

    rst = 1'b0;
    step(0);
    step(1);
    chk("first_sx", 32'(sx), 0);
    chk("first_sy", 32'(sy), 0);
    chk("first_frame_line", 32'({frame, line}), 3);
    chk("first_de", 32'(de), 1);
`ifdef DISPLAY_TESTPAT_EN
    chk("rgb_sx0", 32'({r, g, b}), 32'h FFF);
`endif
    step(0);
    chk("strobe_clear", 32'({frame, line}), 0);

    hs_cnt = 0; de_cnt = 1; hs_first = -1; hs_last = -1;
    for (int i = 1; i < 800; i++) begin
      step(1); step(0);
      if (hsync == 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(sx);
        hs_last = int'(sx);
      end
      if (de) de_cnt++;
`ifdef DISPLAY_TESTPAT_EN
      if (sx == 10'd85)  chk("rgb_sx85",  32'({r, g, b}), 32'h FF0);
      if (sx == 10'd639) chk("rgb_sx639", 32'({r, g, b}), 32'h 000);
      if (sx == 10'd700) chk("rgb_sx700", 32'({r, g, b}), 32'h 000);
`endif
    end
    chk("line0_hs_width", hs_cnt, 96);
    chk("line0_hs_first", hs_first, 656);
    chk("line0_hs_last", hs_last, 751);
    chk("line0_de_count", de_cnt, 640);
    chk("line0_end_sx", 32'(sx), 799);
    step(1);
    chk("line1_sx", 32'(sx), 0);
    chk("line1_sy", 32'(sy), 1);
    chk("line1_strobes", 32'({frame, line}), 1);

    for (int i = 0; i < 300; i++) begin step(0); step(1); end
    chk("freeze_at", 32'(sx), 300);
    for (int i = 0; i < 10; i++) step(0);
    chk("frozen_sx", 32'(sx), 300);
    chk("frozen_sy", 32'(sy), 1);
    step(1);
    chk("resume_sx", 32'(sx), 301);

    for (int i = 0; i < 199; i++) begin step(0); step(1); end
    chk("pre_reset_sx", 32'(sx), 500);
    rst = 1'b1;
    step(1);
    chk("midrst_sx", 32'(sx), 799);
    chk("midrst_sy", 32'(sy), 524);
    chk("midrst_strobes", 32'({line, frame}), 0);
    chk("midrst_de", 32'(de), 0);
    rst = 1'b0;

    // Full frame with pix_ce held high.
    seen_first = 1'b0; done = 1'b0;
    strobes = 0; lines = 0; vs_lines = 0; vs_first = -1; vs_last = -1;
    de_bad = 0; max_x = 0; max_y = 0; p_sx = -1; p_sy = -1;
    for (int i = 0; i < 420010 && !done; i++) begin
      step(1);
      if (seen_first) begin
        strobes++;
        if (line) lines++;
        if (vsync == 1'b0 && sx == 10'd0) begin
          vs_lines++;
          if (vs_first < 0) vs_first = int'(sy);
          vs_last = int'(sy);
        end
        if (de && sy >= 10'd480) de_bad++;
        if (int'(sx) > max_x) max_x = int'(sx);
        if (int'(sy) > max_y) max_y = int'(sy);
      end
      if (frame) begin
        if (!seen_first) begin
          seen_first = 1'b1;
        end else begin
          chk("frame_period", strobes, 800 * 525);
          chk("lines_per_frame", lines, 525);
          chk("wrap_prev_sx", p_sx, 799);
          chk("wrap_prev_sy", p_sy, 524);
          done = 1'b1;
        end
      end
      p_sx = int'(sx);
      p_sy = int'(sy);
    end
    chk("frame_seen", 32'(done), 1);
    chk("vs_lines", vs_lines, 2);
    chk("vs_first", vs_first, 490);
    chk("vs_last", vs_last, 491);
    chk("de_below_active", de_bad, 0);
    chk("max_sx", max_x, 799);
    chk("max_sy", max_y, 524);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
